// File: rtl/cs_left_seq.sv
// Sequential circular left-shifter: rotates a captured word left by one bit per clock,
// then presents the result with a single-cycle done pulse.
module cs_left_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        StIdle,
        StRot,
        StFin
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;

    state_e           w_state_d;
    logic [WIDTH-1:0] w_work_d;
    logic [SHW-1:0]   w_cnt_d;
    logic             w_busy_d;
    logic             w_done_d;
    logic [WIDTH-1:0] w_result_d;

    always_comb begin
        w_state_d  = r_state;
        w_work_d   = r_work;
        w_cnt_d    = r_cnt;
        w_busy_d   = r_busy;
        w_done_d   = 1'b0;
        w_result_d = r_result;

        case (r_state)
            StIdle: begin
                if (start) begin
                    w_work_d  = din;
                    w_cnt_d   = amt;
                    w_busy_d  = 1'b1;
                    // A zero amount skips rotation and goes straight to the result edge.
                    w_state_d = (amt != '0) ? StRot : StFin;
                end
            end
            StRot: begin
                w_work_d = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
                w_cnt_d  = r_cnt - SHW'(1);
                if (r_cnt == SHW'(1)) begin
                    w_state_d = StFin;
                end
            end
            StFin: begin
                w_result_d = r_work;
                w_done_d   = 1'b1;
                w_busy_d   = 1'b0;
                w_state_d  = StIdle;
            end
            default: begin
                w_state_d = StIdle;
                w_busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= StIdle;
            r_work   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_d;
            r_work   <= w_work_d;
            r_cnt    <= w_cnt_d;
            r_busy   <= w_busy_d;
            r_done   <= w_done_d;
            r_result <= w_result_d;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_cs_left_seq.sv
// Scoreboard bench for cs_left_seq: the driver queues expected results and done cycles,
// a negedge monitor checks done timing, result, hold behaviour and the busy window.
module tb_cs_left_seq;

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;
    logic        start  = 1'b0;
    logic [31:0] din    = '0;
    logic [4:0]  amt    = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    cs_left_seq #(
        .WIDTH(32),
        .SHW  (5)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .start (start),
        .din   (din),
        .amt   (amt),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int unsigned at;
    } exp_t;

    exp_t        sbq[$];
    int          errors    = 0;
    int          checks    = 0;
    logic [31:0] held      = '0;
    int unsigned busy_from = 1;
    int unsigned busy_to   = 0;
    int unsigned next_free = 0;

    // Rotate left by taking the upper half of the doubled word shifted left.
    function automatic logic [31:0] rotl_ref(input logic [31:0] x, input logic [4:0] a);
        logic [63:0] t;
        t = {x, x} << a;
        return t[63:32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        check("busy", {31'b0, busy}, {31'b0, (cyc >= busy_from && cyc <= busy_to)});
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done at cycle %0d: got done=1, expected 0", cyc);
            end else begin
                e = sbq.pop_front();
                check("done_cycle", cyc, e.at);
                check("result", result, e.res);
                held = e.res;
            end
        end else begin
            check("done_low", {31'b0, done}, 32'd0);
            check("result_held", result, held);
            if (sbq.size() > 0 && cyc > sbq[0].at) begin
                checks++;
                errors++;
                $display("FAIL overdue at cycle %0d: got no done, expected done at cycle %0d",
                         cyc, sbq[0].at);
                void'(sbq.pop_front());
            end
        end
    end

    // Called at negedge+1; start is sampled on the following edge.
    task automatic issue(input logic [31:0] d, input logic [4:0] a, input logic [31:0] e);
        start = 1'b1;
        din   = d;
        amt   = a;
        sbq.push_back('{e, cyc + {27'b0, a} + 2});
        busy_from = cyc + 1;
        busy_to   = cyc + {27'b0, a} + 1;
        next_free = cyc + {27'b0, a} + 2;
        @(negedge clock);
        #1;
        start = 1'b0;
        din   = $urandom;
        amt   = 5'($urandom);
    endtask

    task automatic wait_cycle(input int unsigned target);
        while (cyc < target) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clock);
            #1;
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL timeout at cycle %0d: got %0d pending results, expected 0",
                     cyc, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        sbq.delete();
        held      = '0;
        busy_from = 1;
        busy_to   = 0;
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] d;
        logic [4:0]  a;
        int unsigned gap;

        // Reset held with start active: outputs must stay at reset values.
        do_reset();
        start = 1'b1;
        repeat (4) begin
            din = $urandom;
            amt = 5'($urandom);
            @(negedge clock);
            #1;
            check("rst_busy", {31'b0, busy}, 32'd0);
            check("rst_result", result, 32'd0);
        end
        start  = 1'b0;
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clock);
            #1;
        end
        next_free = cyc;

        // Basic wrap, then back-to-back in the done cycle.
        issue(32'h8000_0001, 5'd1, 32'h0000_0003);
        wait_cycle(next_free);
        issue(32'h0000_0002, 5'd31, 32'h0000_0001);
        wait_idle();

        issue(32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
        wait_idle();
        issue(32'h0000_0001, 5'd31, 32'h8000_0000);
        wait_idle();

        // Start at E2 while busy must be ignored.
        issue(32'h0000_000F, 5'd4, 32'h0000_00F0);
        start = 1'b1;
        din   = 32'hFFFF_FFFF;
        amt   = 5'd0;
        @(negedge clock);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (4) begin
            @(negedge clock);
            #1;
        end

        // Reset mid-operation just after E7.
        issue($urandom, 5'd20, 32'h0);
        repeat (6) @(posedge clock);
        #2;
        do_reset();
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        repeat (2) @(negedge clock);
        #1;
        resetn = 1'b1;
        @(negedge clock);
        #1;
        issue(32'h1234_5678, 5'd8, 32'h3456_7812);
        wait_idle();

        // Rotate-right-by-1 output fed back with amt=1 must restore the original word.
        x = 32'hA5A5_A5A5;
        issue({x[0], x[31:1]}, 5'd1, x);
        wait_cycle(next_free);
        x = 32'h0000_0001;
        issue({x[0], x[31:1]}, 5'd1, x);
        wait_idle();

        // Random operations with random gaps (including zero) and start noise while busy.
        next_free = cyc;
        for (int i = 0; i < 40; i++) begin
            d   = $urandom;
            a   = 5'($urandom_range(0, 31));
            gap = $urandom_range(0, 2);
            while (cyc < next_free + gap) begin
                start = (cyc < next_free) ? 1'($urandom) : 1'b0;
                din   = $urandom;
                amt   = 5'($urandom);
                @(negedge clock);
                #1;
            end
            issue(d, a, rotl_ref(d, a));
        end
        wait_idle();
        repeat (3) begin
            @(negedge clock);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
